// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: ALU results pass straight through, while loads and stores
// stall upstream and run a request/acknowledge handshake with a watchdog timeout.
module mem_access_stage #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IValid,
    input  logic        IMemRead,
    input  logic        IMemWrite,
    input  logic        IRegWrite,
    input  logic        IRegStore,
    input  logic [15:0] IPCP2,
    input  logic [15:0] IALUResult,
    input  logic [15:0] IWriteData,
    input  logic [2:0]  IRd,
    output logic        MemReq,
    output logic        MemWe,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWData,
    input  logic [15:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic        OValid,
    output logic        ORegWrite,
    output logic        ORegStore,
    output logic [15:0] OPCP2,
    output logic [15:0] OALUResult,
    output logic [15:0] OStoreMem,
    output logic [2:0]  ORd,
    output logic        Fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic        hold_write;
    logic        hold_reg_write;
    logic        hold_reg_store;
    logic [15:0] hold_pcp2;
    logic [15:0] hold_alu;
    logic [15:0] hold_wdata;
    logic [2:0]  hold_rd;
    logic [15:0] rdata;
    logic [7:0]  count;
    logic        abort;
    logic        fault_q;

    logic memop;
    logic timed_out;

    assign memop     = IValid & (IMemRead | IMemWrite);
    assign timed_out = (count == TIMEOUT - 8'd1);
    assign Fault     = fault_q;

    // NOTE: state lives in always_ff with non-blocking assignments; the async
    // reset sits in the sensitivity list so it acts without waiting for CLK.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output is given a default before the case so
    // no path leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (memop) state_next = S_WAIT;
            S_WAIT: if (MemAck || timed_out) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hold_write     <= 1'b0;
            hold_reg_write <= 1'b0;
            hold_reg_store <= 1'b0;
            hold_pcp2      <= 16'h0000;
            hold_alu       <= 16'h0000;
            hold_wdata     <= 16'h0000;
            hold_rd        <= 3'd0;
            rdata          <= 16'h0000;
            count          <= 8'd0;
            abort          <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        hold_write     <= IMemWrite;
                        hold_reg_write <= IRegWrite;
                        hold_reg_store <= IRegStore;
                        hold_pcp2      <= IPCP2;
                        hold_alu       <= IALUResult;
                        hold_wdata     <= IWriteData;
                        hold_rd        <= IRd;
                        count          <= 8'd0;
                        abort          <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (MemAck) begin
                        if (!hold_write) rdata <= MemRData;
                    end else if (timed_out) begin
                        fault_q <= 1'b1;
                        abort   <= 1'b1;
                        rdata   <= 16'hFFFF;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while Reset is high, since IDLE would otherwise
    // reflect the (possibly still present) memop on the inputs.
    always_comb begin
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        MemAddr    = 16'h0000;
        MemWData   = 16'h0000;
        Stall      = 1'b0;
        OValid     = 1'b0;
        ORegWrite  = 1'b0;
        ORegStore  = 1'b0;
        OPCP2      = 16'h0000;
        OALUResult = 16'h0000;
        OStoreMem  = 16'h0000;
        ORd        = 3'd0;
        if (!Reset) begin
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        Stall = 1'b1;
                    end else begin
                        OValid     = IValid;
                        ORegWrite  = IRegWrite;
                        ORegStore  = IRegStore;
                        OPCP2      = IPCP2;
                        OALUResult = IALUResult;
                        ORd        = IRd;
                    end
                end
                S_WAIT: begin
                    MemReq   = 1'b1;
                    MemWe    = hold_write;
                    MemAddr  = hold_alu;
                    MemWData = hold_wdata;
                    Stall    = 1'b1;
                end
                S_RESP: begin
                    OValid     = 1'b1;
                    ORegWrite  = hold_reg_write & ~abort;
                    ORegStore  = hold_reg_store;
                    OPCP2      = hold_pcp2;
                    OALUResult = hold_alu;
                    OStoreMem  = hold_write ? 16'h0000 : rdata;
                    ORd        = hold_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM_WB words are queued as
// instructions are issued and compared whenever OValid is seen.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IValid, IMemRead, IMemWrite, IRegWrite, IRegStore;
    logic [15:0] IPCP2, IALUResult, IWriteData;
    logic [2:0]  IRd;
    logic [15:0] MemRData;
    logic        MemAck;

    logic        MemReq, MemWe, Stall, OValid, ORegWrite, ORegStore, Fault;
    logic [15:0] MemAddr, MemWData, OPCP2, OALUResult, OStoreMem;
    logic [2:0]  ORd;

    logic        t_MemReq, t_MemWe, t_Stall, t_OValid, t_ORegWrite, t_ORegStore, t_Fault;
    logic [15:0] t_MemAddr, t_MemWData, t_OPCP2, t_OALUResult, t_OStoreMem;
    logic [2:0]  t_ORd;

    typedef struct {
        logic        reg_write;
        logic        reg_store;
        logic [15:0] pcp2;
        logic [15:0] alu;
        logic [15:0] store_mem;
        logic [2:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    mem_access_stage dut (
        .CLK(CLK), .Reset(Reset), .IValid(IValid), .IMemRead(IMemRead),
        .IMemWrite(IMemWrite), .IRegWrite(IRegWrite), .IRegStore(IRegStore),
        .IPCP2(IPCP2), .IALUResult(IALUResult), .IWriteData(IWriteData), .IRd(IRd),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall), .OValid(OValid),
        .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OPCP2(OPCP2),
        .OALUResult(OALUResult), .OStoreMem(OStoreMem), .ORd(ORd), .Fault(Fault)
    );

    mem_access_stage #(.TIMEOUT(8'd4)) dut_t (
        .CLK(CLK), .Reset(Reset), .IValid(IValid), .IMemRead(IMemRead),
        .IMemWrite(IMemWrite), .IRegWrite(IRegWrite), .IRegStore(IRegStore),
        .IPCP2(IPCP2), .IALUResult(IALUResult), .IWriteData(IWriteData), .IRd(IRd),
        .MemReq(t_MemReq), .MemWe(t_MemWe), .MemAddr(t_MemAddr), .MemWData(t_MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .Stall(t_Stall), .OValid(t_OValid),
        .ORegWrite(t_ORegWrite), .ORegStore(t_ORegStore), .OPCP2(t_OPCP2),
        .OALUResult(t_OALUResult), .OStoreMem(t_OStoreMem), .ORd(t_ORd), .Fault(t_Fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic set_inputs(input logic v, input logic rd_en, input logic wr_en,
                              input logic rw, input logic rs, input logic [15:0] pcp2,
                              input logic [15:0] alu, input logic [15:0] wdata,
                              input logic [2:0] rd);
        IValid     = v;
        IMemRead   = rd_en;
        IMemWrite  = wr_en;
        IRegWrite  = rw;
        IRegStore  = rs;
        IPCP2      = pcp2;
        IALUResult = alu;
        IWriteData = wdata;
        IRd        = rd;
        MemAck     = 1'b0;
        MemRData   = 16'h0000;
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        @(negedge CLK);
        check("idle_ovalid", 32'(OValid), 0);
    endtask

    task automatic apply_alu(input logic rw, input logic rs, input logic [15:0] pcp2,
                             input logic [15:0] alu, input logic [2:0] rd);
        @(posedge CLK); #1;
        set_inputs(1'b1, 1'b0, 1'b0, rw, rs, pcp2, alu, 16'h5A5A, rd);
        sb.push_back('{rw, rs, pcp2, alu, 16'h0000, rd});
        @(negedge CLK);
        check("alu_ovalid", 32'(OValid), 1);
        check("alu_stall", 32'(Stall), 0);
        check("alu_memreq", 32'(MemReq), 0);
    endtask

    // ack_wait: the WAIT cycle (1-based) in which MemAck is pulsed.
    task automatic apply_mem(input logic rd_en, input logic wr_en, input logic rw,
                             input logic rs, input logic [15:0] pcp2, input logic [15:0] alu,
                             input logic [15:0] wdata, input logic [2:0] rd,
                             input int ack_wait, input logic [15:0] rdata);
        int lat = 0;
        int stalls = 0;
        @(posedge CLK); #1;
        set_inputs(1'b1, rd_en, wr_en, rw, rs, pcp2, alu, wdata, rd);
        sb.push_back('{rw, rs, pcp2, alu, (wr_en ? 16'h0000 : rdata), rd});
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) begin
                @(posedge CLK); #1;
                MemAck   = (cyc == ack_wait + 1);
                MemRData = MemAck ? rdata : 16'hDEAD;
            end
            @(negedge CLK);
            if (OValid) begin
                lat = cyc;
                break;
            end
            stalls += int'(Stall);
            if (cyc == 1) begin
                check("detect_stall", 32'(Stall), 1);
                check("detect_memreq", 32'(MemReq), 0);
            end else begin
                check("wait_memreq", 32'(MemReq), 1);
                check("wait_memwe", 32'(MemWe), 32'(wr_en));
                check("wait_addr", 32'(MemAddr), 32'(alu));
                check("wait_wdata", 32'(MemWData), 32'(wdata));
            end
        end
        check("mem_latency", 32'(lat), 32'(ack_wait + 2));
        check("stall_cycles", 32'(stalls), 32'(ack_wait + 1));
        check("resp_stall", 32'(Stall), 0);
        check("resp_memreq", 32'(MemReq), 0);
    endtask

    always @(negedge CLK) begin
        if (!Reset && OValid) begin
            if (sb.size() == 0) begin
                check("unexpected_ovalid", 32'(OValid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("o_regwrite", 32'(ORegWrite), 32'(mon_e.reg_write));
                check("o_regstore", 32'(ORegStore), 32'(mon_e.reg_store));
                check("o_pcp2", 32'(OPCP2), 32'(mon_e.pcp2));
                check("o_alu", 32'(OALUResult), 32'(mon_e.alu));
                check("o_storemem", 32'(OStoreMem), 32'(mon_e.store_mem));
                check("o_rd", 32'(ORd), 32'(mon_e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        int lat;
        logic [15:0] r_addr, r_data;
        int r_ack;
        logic r_wr;

        Reset = 1'b1;
        set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0102, 16'h1234, 16'h0000, 3'd3);
        #12;
        check("rst_ovalid", 32'(OValid), 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_memreq", 32'(MemReq), 0);
        check("rst_alu", 32'(OALUResult), 0);
        check("rst_rd", 32'(ORd), 0);
        check("rst_fault", 32'(Fault), 0);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        apply_alu(1'b1, 1'b0, 16'h0102, 16'h1234, 3'd3);
        apply_alu(1'b0, 1'b1, 16'h0F00, 16'hABCD, 3'd7);
        apply_mem(1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0040, 16'h0000, 3'd2, 1, 16'hBEEF);
        apply_mem(1'b0, 1'b1, 1'b0, 1'b0, 16'h0204, 16'h0050, 16'h00AA, 3'd0, 5, 16'h7777);
        apply_mem(1'b1, 1'b1, 1'b0, 1'b0, 16'h0206, 16'h0010, 16'h0033, 3'd1, 2, 16'h5555);
        apply_mem(1'b1, 1'b0, 1'b1, 1'b1, 16'h0208, 16'h0100, 16'h0000, 3'd4, 3, 16'h0F0F);
        apply_mem(1'b1, 1'b0, 1'b1, 1'b0, 16'h020A, 16'h0102, 16'h0000, 3'd5, 1, 16'h1357);
        apply_alu(1'b1, 1'b0, 16'h020C, 16'h4242, 3'd6);
        idle_cycle();

        @(posedge CLK); #1;
        MemAck = 1'b1;
        MemRData = 16'hCAFE;
        @(negedge CLK);
        check("stray_ack_ovalid", 32'(OValid), 0);
        check("stray_ack_stall", 32'(Stall), 0);
        idle_cycle();

        for (int i = 0; i < 4; i++) begin
            r_addr = 16'($urandom);
            r_data = 16'($urandom);
            r_ack  = int'($urandom_range(1, 6));
            r_wr   = 1'($urandom);
            apply_mem(~r_wr, r_wr, 1'b1, 1'b0, 16'(i * 2), r_addr, ~r_data, 3'(i), r_ack, r_data);
        end
        idle_cycle();
        check("no_fault_main", 32'(Fault), 0);

        // Timeout on the TIMEOUT=4 instance; the default instance just waits.
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        check("t_fault_cleared", 32'(t_Fault), 0);
        set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0080, 16'h0000, 3'd5);
        waits = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc > 1) @(posedge CLK);
            @(negedge CLK);
            if (t_OValid) begin
                lat = cyc;
                break;
            end
            waits += int'(t_MemReq);
        end
        check("to_wait_cycles", 32'(waits), 4);
        check("to_latency", 32'(lat), 6);
        check("to_storemem", 32'(t_OStoreMem), 32'hFFFF);
        check("to_regwrite", 32'(t_ORegWrite), 0);
        check("to_alu", 32'(t_OALUResult), 32'h0080);
        check("to_fault", 32'(t_Fault), 1);
        @(posedge CLK); #1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("to_fault_sticky", 32'(t_Fault), 1);
        Reset = 1'b1;
        #1;
        check("to_fault_reset", 32'(t_Fault), 0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        // Reset asserted mid-cycle during the second WAIT cycle.
        set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0200, 16'h0000, 3'd2);
        @(posedge CLK);
        @(posedge CLK); #1;
        check("rw_memreq_before", 32'(MemReq), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("rw_memreq", 32'(MemReq), 0);
        check("rw_stall", 32'(Stall), 0);
        check("rw_ovalid", 32'(OValid), 0);
        check("rw_alu", 32'(OALUResult), 0);
        @(posedge CLK); #1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        Reset = 1'b0;
        @(posedge CLK); #1;
        MemAck = 1'b1;
        MemRData = 16'hAAAA;
        @(negedge CLK);
        check("rw_stray_ovalid", 32'(OValid), 0);
        check("rw_stray_memreq", 32'(MemReq), 0);
        @(posedge CLK); #1;
        MemAck = 1'b0;
        @(negedge CLK);
        check("rw_after_ovalid", 32'(OValid), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
